mem_share_ctrl: RTL and testbench

- Round-robin controller sharing one single-port synchronous 256x32 memory between NUM_REQ requesters.
- Each requester issues one read or write with a valid/ready handshake and receives exactly one response pulse.
- Sits between the bench agents (or upstream masters) and the memory; it alone drives the memory enable, write, address and data pins.

---
 rtl/mem_share_pkg.sv | 35 +++
 rtl/mem_share_pick.sv | 33 +++
 rtl/mem_share_ctrl.sv | 117 +++++++++++
 tb/tb_mem_share_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_share_pkg.sv
// Shared types, default widths and the wrap-around first-set-bit search for mem_share_ctrl.
package mem_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int MAX_REQ     = 8;
    localparam int MAX_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index of the first set bit of vec[0..n-1], scanning upward from start with wrap.
    // Returns start when no bit is set; callers qualify the result with |vec.
    function automatic int unsigned first_set_wrap(input logic [MAX_REQ-1:0] vec,
                                                   input int unsigned         start,
                                                   input int unsigned         n);
        int unsigned idx;
        logic        found;
        first_set_wrap = start;
        found          = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (!found && (k < n) && vec[idx[MAX_IDX_W-1:0]]) begin
                first_set_wrap = idx;
                found          = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mem_share_pick.sv
// Combinational winner select; MEMSHARE_FIXED_PRIO_EN switches to lowest-index-wins with no pointer.
module mem_share_pick
    import mem_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
`ifndef MEMSHARE_FIXED_PRIO_EN
    input  logic [PTR_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int unsigned start;
    int unsigned win;

    always_comb begin
        start = 0;
`ifndef MEMSHARE_FIXED_PRIO_EN
        // Search begins just after the last winner so every requester gets a turn.
        if (32'(ptr) >= 32'(NUM_REQ - 1)) start = 0;
        else                              start = 32'(ptr) + 1;
`endif
        win   = first_set_wrap(MAX_REQ'(valid), start, NUM_REQ);
        any   = |valid;
        idx   = PTR_W'(win);
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mem_share_ctrl.sv
// Round-robin sharing of one single-port synchronous memory; one transaction per 3 cycles.
// Define MEMSHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_share_ctrl
    import mem_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     win;
    logic                 any;
    logic                 accept;

    logic [PTR_W-1:0]     owner_p1;
    logic                 we_p1;
    logic [ADDR_W-1:0]    addr_p1;
    logic [DATA_W-1:0]    wdata_p1;

`ifndef MEMSHARE_FIXED_PRIO_EN
    logic [PTR_W-1:0]     ptr;
`endif

    mem_share_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_valid),
`ifndef MEMSHARE_FIXED_PRIO_EN
        .ptr   (ptr),
`endif
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        mem_en    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any) begin
                    accept    = 1'b1;
                    req_ready = grant;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                // Read data passes straight through from the memory's registered output.
                rsp_valid = NUM_REQ'(1) << owner_p1;
                if (!we_p1) rsp_rdata = mem_rdata;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage -> issue stage: request captured, drives the memory pins until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_p1 <= '0;
            we_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else if (accept) begin
            owner_p1 <= win;
            we_p1    <= req_we[win];
            addr_p1  <= req_addr[win*ADDR_W +: ADDR_W];
            wdata_p1 <= req_wdata[win*DATA_W +: DATA_W];
        end
    end

`ifndef MEMSHARE_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst)         ptr <= PTR_W'(NUM_REQ - 1);
        else if (accept) ptr <= win;
    end
`endif

    assign mem_we    = we_p1;
    assign mem_addr  = addr_p1;
    assign mem_wdata = wdata_p1;

endmodule

// File: tb/tb_mem_share_ctrl.sv
// Directed self-checking bench for mem_share_ctrl with a 256x32 synchronous memory model.
// Honours MEMSHARE_FIXED_PRIO_EN when choosing the expected starvation grant order.
module tb_mem_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;
    logic                      load;

    logic [DATA_W-1:0]         mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_share_ctrl #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction; starts and ends on a falling edge with the DUT idle.
    task automatic txn(input int id, input logic we, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        int n;
        req_valid[id]          = 1'b1;
        req_we[id]             = we;
        req_addr[id*8 +: 8]    = a;
        req_wdata[id*32 +: 32] = wd;
        #1;
        n = 0;
        while (!req_ready[id] && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept_ready", 32'(req_ready), 32'(1 << id));
        check("accept_busy", 32'(busy), 32'd0);
        check("accept_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        check("issue_en", 32'(mem_en), 32'd1);
        check("issue_we", 32'(mem_we), 32'(we));
        check("issue_addr", 32'(mem_addr), 32'(a));
        if (we) check("issue_wdata", mem_wdata, wd);
        check("issue_busy", 32'(busy), 32'd1);
        @(negedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'(1 << id));
        check("resp_rdata", rsp_rdata, exp_rd);
        check("resp_ready", 32'(req_ready), 32'd0);
        check("resp_en", 32'(mem_en), 32'd0);
        @(negedge clk);
    endtask

    // One grant under continuous contention; requester k always reads address k.
    task automatic grant_cycle(input int exp);
        #1;
        check("cont_ready", 32'(req_ready), 32'(1 << exp));
        check("cont_idle_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check("cont_issue_addr", 32'(mem_addr), 32'(exp));
        check("cont_issue_busy", 32'(busy), 32'd1);
        @(negedge clk); #1;
        check("cont_rsp_valid", 32'(rsp_valid), 32'(1 << exp));
        check("cont_rsp_rdata", rsp_rdata, 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        load      = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        load = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, then write followed by read-after-write from another requester.
        txn(2, 1'b0, 8'd5, 32'd0, 32'd5);
        txn(0, 1'b1, 8'd17, 32'hDEADBEEF, 32'd0);
        txn(1, 1'b0, 8'd17, 32'd0, 32'hDEADBEEF);

        // Full contention after reset: rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_we[k]          = 1'b0;
            req_addr[k*8 +: 8] = 8'(k);
        end
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) grant_cycle(g % 4);
        req_valid = '0;
        @(negedge clk);

        // Requesters 0 and 3 always valid.
        do_reset();
        req_valid = 4'b1001;
        for (int g = 0; g < 4; g++) begin
`ifdef MEMSHARE_FIXED_PRIO_EN
            grant_cycle(0);
`else
            grant_cycle((g % 2 == 0) ? 0 : 3);
`endif
        end
        req_valid = '0;
        @(negedge clk);

        // Reset while a read of addr 9 sits in ISSUE.
        req_valid[1]     = 1'b1;
        req_we[1]        = 1'b0;
        req_addr[8 +: 8] = 8'd9;
        #1;
        check("rsti_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rsti_issue_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rsti_no_rsp", 32'(rsp_valid), 32'd0);
        check("rsti_busy", 32'(busy), 32'd0);
        check("rsti_mem_en", 32'(mem_en), 32'd0);
        check("rsti_mem_addr", 32'(mem_addr), 32'd0);
        rst              = 1'b0;
        req_addr[0 +: 8] = 8'd33;
        req_addr[16 +: 8] = 8'd2;
        req_valid        = 4'b0101;
        #1;
        check("rsti_first_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        check("rsti_after_rsp", 32'(rsp_valid), 32'b0001);
        check("rsti_after_rdata", rsp_rdata, 32'd33);
        @(negedge clk);

        // Address extremes, back to back.
        txn(3, 1'b0, 8'd0, 32'd0, 32'd0);
        txn(3, 1'b0, 8'd255, 32'd0, 32'd255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
